// File: rtl/sha_digest_uart_tx.sv
// sha_digest_uart_tx: captures the 256-bit SHA-256 digest on a rising edge of hash_done.
// It sends the digest as 64 ASCII hex characters, optionally followed by CR LF, over a
// UART 8N1 line. There is no gap between characters.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   signature  [0:255] digest, bit 0 is the MSB of H0
//   hash_done  completion level from the hash core; only its rising edge triggers
//   tx         registered serial output, idles high
//   busy       high from capture until tx_done
//   tx_done    one-cycle pulse after the last stop bit
//   drop_err   one-cycle pulse when a new digest arrives while busy
module sha_digest_uart_tx #(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter bit          HEX_UPPER    = 1'b0,
  parameter bit          APPEND_CRLF  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [0:255] signature,
  input  logic         hash_done,
  output logic         tx,
  output logic         busy,
  output logic         tx_done,
  output logic         drop_err
);

  localparam int unsigned NumChars = APPEND_CRLF ? 66 : 64;
  localparam int unsigned CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [6:0]      LastChar = 7'(NumChars - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [6:0]      char_q, char_d;
  logic [255:0]    shreg_q, shreg_d;
  logic            hd_q;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            drop_q, drop_d;

  logic       rise;
  logic       baud_wrap;
  logic [3:0] nib;
  logic [7:0] cur_char;

  assign rise      = hash_done & ~hd_q;
  assign baud_wrap = (baud_q == CntMax);
  // The leading nibble always sits at the top; the register shifts left once per character.
  assign nib       = shreg_q[255:252];

  always_comb begin
    cur_char = 8'h0a;
    if (char_q < 7'd64) begin
      if (nib < 4'd10) cur_char = 8'h30 + {4'h0, nib};
      else             cur_char = (HEX_UPPER ? 8'h37 : 8'h57) + {4'h0, nib};
    end else if (char_q == 7'd64) begin
      cur_char = 8'h0d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_wrap ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    char_d  = char_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    // DONE still counts as busy, so an edge there is dropped.
    drop_d  = rise && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (rise) begin
          shreg_d = signature;
          busy_d  = 1'b1;
          char_d  = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_wrap) begin
          tx_d    = cur_char[0];
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_char[bit_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (baud_wrap) begin
          if (char_q == LastChar) begin
            state_d = DONE;
          end else begin
            char_d  = char_q + 7'd1;
            shreg_d = {shreg_q[251:0], 4'h0};
            tx_d    = 1'b0;
            state_d = START;
          end
        end
      end
      DONE: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      char_q  <= '0;
      shreg_q <= '0;
      // Reset high so a level held across reset is not seen as a new digest.
      hd_q    <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      shreg_q <= shreg_d;
      hd_q    <= hash_done;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;
  assign drop_err = drop_q;

endmodule

// File: doc/sha_digest_uart_tx.md
Name: sha_digest_uart_tx

Overview:
Return path of the SHA-256 UART design. It captures the 256-bit digest from the hash core when the core raises hash_done. It sends the digest as 64 ASCII hex characters, optionally followed by CR LF, over a UART 8N1 serial line. It sits between the hash core's signature/hash_done outputs and the board TX pin.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, serial bit rate
CLKS_PER_BIT, CLK_FREQ/BAUD (integer divide, 434 at defaults), clock cycles per serial bit; must be >= 2
HEX_UPPER, 0, 1 = use 'A'-'F' for hex digits 10-15, 0 = use 'a'-'f'
APPEND_CRLF, 1, 1 = send 0x0D then 0x0A after the 64 hex characters

Ports:
clk  input  1  system clock, all logic on the rising edge
rst_n  input  1  asynchronous, active-low reset
signature  input  [0:255]  digest from the hash core; bit 0 is the MSB of H0
hash_done  input  1  core completion flag; level, may stay high indefinitely
tx  output  1  UART serial out; idles high
busy  output  1  high from digest capture until tx_done
tx_done  output  1  one-cycle pulse after the last stop bit
drop_err  output  1  one-cycle pulse when a new digest arrives while busy

Behaviour:
- Reset is asynchronous on rst_n low and takes effect immediately:
  - tx=1, busy=0, tx_done=0, drop_err=0.
  - FSM returns to IDLE; bit counter, character counter and baud counter clear.
  - The hash_done history register hd_q resets to 1, so a hash_done level held across reset is not treated as new.
- Trigger: a rising edge of hash_done, defined as hash_done=1 while hd_q=0. hd_q samples hash_done every cycle.
- Capture (IDLE with a rising edge):
  - On that clock edge, signature is loaded into a 256-bit shift register and busy goes to 1.
  - The FSM moves to START and tx goes low on the same edge.
  - So the start bit begins 1 cycle after the edge is sampled.
- A rising edge while busy=1:
  - drop_err pulses for exactly 1 cycle.
  - The digest is not captured; the transmission in progress is unaffected.
- Character order:
  - Nibbles are sent MSB-first: signature[0:3], then [4:7], and so on up to [252:255].
  - Nibble 0-9 maps to 0x30-0x39.
  - Nibble 10-15 maps to 0x61-0x66, or to 0x41-0x46 when HEX_UPPER=1.
  - Character count is 64 hex characters, plus 2 when APPEND_CRLF=1.
- FSM states: IDLE, START, DATA, STOP, DONE.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If characters remain, advance the character index and go directly to START (no inter-character gap).
    - Otherwise go to DONE.
  - DONE: single cycle; tx=1, tx_done=1, busy=0 on exit, then go to IDLE.
- Timing:
  - Baud counter counts 0 to CLKS_PER_BIT-1; a bit boundary occurs on the wrap.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - The total from start-bit entry to tx_done is N_chars*10*CLKS_PER_BIT cycles, plus 1 cycle for DONE.
- Simultaneous events:
  - A rising edge in the DONE cycle counts as busy: drop_err pulses.
  - A rising edge in the cycle after DONE (IDLE) is accepted normally.
- tx is registered, so no combinational path from inputs to tx.
- Characters are generated from the shift register, not re-read from signature, so signature may change after capture without effect.

Test Plan:
1. CLK_FREQ=8, BAUD=1 (8 clocks/bit), APPEND_CRLF=1; signature=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, hash_done 0->1 -> UART decoder receives the string "ba7816bf...15ad" then 0x0D 0x0A. tx_done pulses 66*80+1=5281 cycles after tx first falls; busy is high throughout.
2. Bit timing on the first character 'b' (0x62) -> tx low 8 cycles (start), then data bits 0,1,0,0,0,1,1,0 each 8 cycles, then high 8 cycles (stop), then the next start bit immediately.
3. signature all-zero -> 64 x 0x30. All-ones with HEX_UPPER=1 -> 64 x 0x46. All-ones with HEX_UPPER=0 -> 64 x 0x66. With APPEND_CRLF=0, exactly 64 frames.
4. hash_done dropped and re-raised during character 10 -> drop_err is a single-cycle pulse and the output stream is byte-identical to test 1. A re-raise in the cycle after tx_done -> a second full digest is sent.
5. rst_n low mid-DATA of character 5 -> tx=1, busy=0 asynchronously before the next clk edge. After release with hash_done still high -> no transmission and tx stays 1 for 1000 cycles.
6. hash_done held high across two captures without falling -> only one transmission and no drop_err.
